// File: rtl/conv_channel_multi.sv
// Multi-channel 3x3 stride-1 convolution (correlation: tap (a,b) weights pixel (r+a-1, c+b-1)),
// summed over all channels, with optional zero padding and ReLU. Pipeline: window -> products -> sum -> result.
module conv_channel_multi #(
    parameter int DataWidth = 64,
    parameter int Channels  = 4,
    parameter int MaxCols   = 256,
    parameter int DimWidth  = 9
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          start,
    input  logic [DimWidth-1:0]           row_in,
    input  logic [DimWidth-1:0]           col_in,
    input  logic                          pad_en,
    input  logic                          relu_en,
    input  logic [Channels*DataWidth-1:0] weight_in,
    input  logic                          weight_valid,
    input  logic [Channels*DataWidth-1:0] data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic [DataWidth-1:0]          result_out,
    output logic                          result_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int PixW  = Channels * DataWidth;
    localparam int StepW = 2 * DimWidth + 1;
    localparam int PtrW  = (MaxCols > 1) ? $clog2(MaxCols) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t               r_state, w_next_state;
    logic [DimWidth-1:0]  r_rows_m1, r_cols_m1;
    logic                 r_pad, r_relu;
    logic [StepW-1:0]     r_npix, r_total, r_lead, r_step;
    logic [PtrW-1:0]      r_pc;
    logic [DimWidth-1:0]  r_cr, r_cc;
    logic [3:0]           r_wcnt;
    logic [PixW-1:0]      r_w   [9];
    logic [PixW-1:0]      r_lb0 [MaxCols];
    logic [PixW-1:0]      r_lb1 [MaxCols];
    logic [PixW-1:0]      r_win [3][3];
    logic                 r_v1, r_v2, r_v3;
    logic [8:0]           r_tap_mask;
    logic [DataWidth-1:0] r_prod [9][Channels];
    logic [DataWidth-1:0] r_sum;

    logic                 w_start_ok, w_step, w_last_pix, w_cen_ok, w_emit;
    logic                 w_pc_last, w_top, w_bot, w_left, w_right;
    logic [PixW-1:0]      w_pix, w_lb0_rd, w_lb1_rd;
    logic [8:0]           w_mask;
    logic [DataWidth-1:0] w_sum;

    assign w_start_ok = (r_state == S_IDLE) && start && (int'(row_in) >= 3) &&
                        (int'(col_in) >= 3) && (int'(col_in) <= MaxCols);
    // One step per accepted pixel, plus zero-valued virtual pixels that drain the padded border.
    assign w_step     = ((r_state == S_RUN) && data_valid) ||
                        ((r_state == S_FLUSH) && (r_step < r_total));
    assign w_last_pix = (r_state == S_RUN) && data_valid && (r_step == r_npix - StepW'(1));
    assign w_pix      = (r_state == S_RUN) ? data_in : '0;
    assign w_cen_ok   = (r_step >= r_lead);
    assign w_pc_last  = (r_pc == PtrW'(r_cols_m1));
    assign w_top      = (r_cr == '0);
    assign w_bot      = (r_cr == r_rows_m1);
    assign w_left     = (r_cc == '0);
    assign w_right    = (r_cc == r_cols_m1);
    assign w_emit     = w_step && w_cen_ok &&
                        (r_pad || (!w_top && !w_bot && !w_left && !w_right));
    assign w_lb0_rd   = r_lb0[r_pc];
    assign w_lb1_rd   = r_lb1[r_pc];

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) r_state <= S_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: default assignment first so no path through this block can infer a latch.
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_start_ok) w_next_state = S_LOAD_W;
            S_LOAD_W: if (weight_valid && (r_wcnt == 4'd8)) w_next_state = S_RUN;
            S_RUN:    if (w_last_pix) w_next_state = S_FLUSH;
            S_FLUSH:  if (!w_step && !r_v1 && !r_v2 && !r_v3 && !result_valid) w_next_state = S_DONE;
            S_DONE:   w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        data_ready = (r_state == S_RUN);
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_rows_m1 <= '0;
            r_cols_m1 <= '0;
            r_pad     <= 1'b0;
            r_relu    <= 1'b0;
            r_npix    <= '0;
            r_total   <= '0;
            r_lead    <= '0;
            r_step    <= '0;
            r_pc      <= '0;
            r_cr      <= '0;
            r_cc      <= '0;
            r_wcnt    <= '0;
            for (int t = 0; t < 9; t++) r_w[t] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            if (w_start_ok) begin
                r_rows_m1 <= row_in - DimWidth'(1);
                r_cols_m1 <= col_in - DimWidth'(1);
                r_pad     <= pad_en;
                r_relu    <= relu_en;
                r_npix    <= StepW'(row_in) * StepW'(col_in);
                r_total   <= StepW'(row_in) * StepW'(col_in) +
                             (pad_en ? (StepW'(col_in) + StepW'(1)) : StepW'(0));
                r_lead    <= StepW'(col_in) + StepW'(1);
                r_step    <= '0;
                r_pc      <= '0;
                r_cr      <= '0;
                r_cc      <= '0;
                r_wcnt    <= '0;
            end
            if ((r_state == S_LOAD_W) && weight_valid) begin
                r_w[r_wcnt] <= weight_in;
                r_wcnt      <= r_wcnt + 4'd1;
            end
            if (w_step) begin
                r_step <= r_step + StepW'(1);
                r_pc   <= w_pc_last ? '0 : r_pc + PtrW'(1);
                // Window centre trails the newest pixel by one row and one column.
                if (w_cen_ok) begin
                    if (w_right) begin
                        r_cc <= '0;
                        r_cr <= r_cr + DimWidth'(1);
                    end else begin
                        r_cc <= r_cc + DimWidth'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            // NOTE: the line buffers are cleared here so no pixel of an aborted frame survives reset.
            for (int i = 0; i < MaxCols; i++) begin
                r_lb0[i] <= '0;
                r_lb1[i] <= '0;
            end
            for (int a = 0; a < 3; a++)
                for (int b = 0; b < 3; b++)
                    r_win[a][b] <= '0;
        end else if (w_step) begin
            r_lb0[r_pc] <= w_lb1_rd;
            r_lb1[r_pc] <= w_pix;
            for (int a = 0; a < 3; a++) begin
                r_win[a][0] <= r_win[a][1];
                r_win[a][1] <= r_win[a][2];
            end
            r_win[0][2] <= w_lb0_rd;
            r_win[1][2] <= w_lb1_rd;
            r_win[2][2] <= w_pix;
        end
    end

    // Taps that fall outside the image read as zero; the stale window contents there are never used.
    always_comb begin
        w_mask = '0;
        for (int t = 0; t < 9; t++)
            w_mask[t] = r_pad && (((t / 3) == 0 && w_top) || ((t / 3) == 2 && w_bot) ||
                                  ((t % 3) == 0 && w_left) || ((t % 3) == 2 && w_right));
    end

    always_comb begin
        w_sum = '0;
        for (int t = 0; t < 9; t++)
            for (int ch = 0; ch < Channels; ch++)
                w_sum = w_sum + r_prod[t][ch];
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_v3         <= 1'b0;
            r_tap_mask   <= '0;
            r_sum        <= '0;
            result_valid <= 1'b0;
            result_out   <= '0;
            for (int t = 0; t < 9; t++)
                for (int ch = 0; ch < Channels; ch++)
                    r_prod[t][ch] <= '0;
        end else begin
            r_v1 <= w_emit;
            if (w_emit) r_tap_mask <= w_mask;
            r_v2 <= r_v1;
            if (r_v1) begin
                for (int t = 0; t < 9; t++)
                    for (int ch = 0; ch < Channels; ch++)
                        r_prod[t][ch] <= r_tap_mask[t] ? '0 :
                            DataWidth'($signed(r_w[t][ch*DataWidth +: DataWidth]) *
                                       $signed(r_win[t/3][t%3][ch*DataWidth +: DataWidth]));
            end
            r_v3 <= r_v2;
            if (r_v2) r_sum <= w_sum;
            result_valid <= r_v3;
            if (r_v3) result_out <= (r_relu && r_sum[DataWidth-1]) ? '0 : r_sum;
        end
    end

endmodule

// File: doc/conv_channel_multi.md
Name: conv_channel_multi

Overview:
Parametrised multi-channel 3x3 convolution engine, stride 1. Streams an R x C image of Channels input planes in row-major order. Emits one output plane: the sum over channels and taps, with optional zero-padding and optional ReLU. It is the generalised successor to the fixed 4-channel, always-padded conv channel, and sits between the feature-map streamer and the accumulation/pooling stage.

Parameters:
DataWidth, 64, width of each signed sample, weight and result
Channels, 4, number of input planes summed into one output
MaxCols, 256, line-buffer depth; largest legal col_in
DimWidth, 9, width of row_in/col_in

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse in IDLE; samples row_in, col_in, pad_en, relu_en
row_in  in  DimWidth  image rows R, 3..2^DimWidth-1
col_in  in  DimWidth  image cols C, 3..MaxCols
pad_en  in  1  1 = zero pad of 1 with RxC output; 0 = (R-2)x(C-2) output
relu_en  in  1  1 = negative results clamp to 0
weight_in  in  Channels*DataWidth  channel ch at [ch*DataWidth +: DataWidth]
weight_valid  in  1  weight beat strobe
data_in  in  Channels*DataWidth  one pixel, all channels, same packing
data_valid  in  1  pixel strobe
data_ready  out  1  high only in RUN; a pixel is accepted when data_valid && data_ready
result_out  out  DataWidth  signed result
result_valid  out  1  one-cycle strobe per result
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after the final result

Behaviour:
- Reset (async, Rst_n=0):
  - Outputs: result_out=0, result_valid=0, data_ready=0, busy=0, done=0.
  - State goes to IDLE. Weights, counters and line buffers are cleared.
  - Reset mid-operation aborts the frame with no further results.
- FSM: IDLE -start-> LOAD_W -9th weight beat-> RUN -last pixel accepted-> FLUSH -last result issued and pipeline empty-> DONE (1 cycle, done=1) -> IDLE.
- start outside IDLE is ignored.
- Weights:
  - LOAD_W takes exactly 9 weight_valid beats; gaps are allowed.
  - Beat k is tap (k/3, k%3), row-major.
  - weight_valid outside LOAD_W is ignored.
- Data:
  - Exactly R*C pixels are accepted in RUN; gaps are allowed.
  - data_valid in other states is ignored.
- Window: pixels outside the image read as 0 when pad_en=1.
- Arithmetic:
  - Products and sums are signed, modulo 2^DataWidth; overflow wraps and is not saturated.
  - ReLU is applied after the full sum.
- Output order: row-major, at most one result per cycle.
- pad_en=1 timing:
  - Output index k (0..R*C-1) is triggered by acceptance of pixel k+C+1.
  - result_valid is asserted exactly 3 cycles after the triggering acceptance edge.
  - Outputs k >= R*C-C-1 have no trigger pixel. In FLUSH they issue on consecutive cycles, as if data_valid were held high from the cycle after the last acceptance.
- pad_en=0 timing:
  - Output (r,c), r,c in 0..R-3, C-2 per row, is triggered by pixel (r+2,c+2), with the same 3-cycle latency.
  - FLUSH only drains the pipeline.
- Boundaries:
  - C=3 with pad_en=0 gives one result per row from row 2.
  - R=3 with pad_en=0 gives one row of results.
  - Line-buffer pointers wrap at C, not at MaxCols.
- Illegal sizes (R<3, C<3, C>MaxCols): start is ignored and the block stays in IDLE.

Test Plan:
- Channels=4, R=C=4, pad_en=1, all weights and pixels = 1 -> 16 results: corners 16, edges 24, interior 36; done pulses once; busy then falls.
- Same stimulus with pad_en=0 -> exactly 4 results, all 36. First result_valid comes 3 cycles after acceptance of pixel (2,2), index 10.
- pad_en=1, back-to-back pixels, C=4 -> first result 3 cycles after pixel index 5; results then follow every cycle with no gaps through FLUSH.
- Weights all -1, pixels all 1, relu_en=1 -> all 16 results 0. With relu_en=0: corners -16, edges -24, interior -36.
- Random data with 1-3 idle cycles between data_valid beats, R=6, C=5 -> results match a golden model in order and count (30).
- Rst_n pulsed low mid-RUN -> outputs 0 asynchronously, no result_valid or done afterwards. A new start then yields a correct full frame.
